// File: rtl/axi_crossbar_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_crossbar_rr_arbiter
//
// Purpose:
//   Round-robin N:1 arbiter for one AXI crossbar channel. It merges NB_REQ
//   valid/ready request streams into a single registered valid/data/id
//   stream. The output register gives one stage of buffering and still runs
//   at full throughput: one grant per cycle while the downstream is ready.
//
// Ports:
//   aclk     - clock, all logic on the rising edge
//   aresetn  - asynchronous active-low reset
//   srst     - synchronous active-high reset (same effect as aresetn)
//   i_valid  - per-requester valid
//   i_data   - packed payloads, requester k at [k*DATA_BUS_W +: DATA_BUS_W]
//   i_ready  - per-requester ready, one-hot or zero
//   o_valid  - registered output valid
//   o_data   - registered payload of the granted requester
//   o_id     - registered index of the granted requester
//   o_ready  - downstream ready
// ---------------------------------------------------------------------------
module axi_crossbar_rr_arbiter #(
  parameter int NB_REQ     = 4,
  parameter int DATA_BUS_W = 16,
  parameter int ID_W       = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         srst,
  input  logic [NB_REQ-1:0]            i_valid,
  input  logic [NB_REQ*DATA_BUS_W-1:0] i_data,
  output logic [NB_REQ-1:0]            i_ready,
  output logic                         o_valid,
  output logic [DATA_BUS_W-1:0]        o_data,
  output logic [ID_W-1:0]              o_id,
  input  logic                         o_ready
);

  localparam logic [ID_W:0]   NbReqW  = (ID_W+1)'(NB_REQ);
  localparam logic [ID_W-1:0] LastIdx = ID_W'(NB_REQ - 1);

  logic                  valid_q, valid_d;
  logic [DATA_BUS_W-1:0] data_q,  data_d;
  logic [ID_W-1:0]       id_q,    id_d;
  logic [ID_W-1:0]       ptr_q,   ptr_d;

  logic                  slotFree;
  logic                  winnerFound;
  logic [ID_W-1:0]       winner;
  logic [ID_W:0]         cand;
  logic [DATA_BUS_W-1:0] winnerData;
  logic                  grant;

  // The output register can take a new beat when empty or being drained.
  assign slotFree = !valid_q || o_ready;

  // Search ptr, ptr+1, ... with an explicit wrap at NB_REQ so that a
  // non-power-of-two requester count never yields an out-of-range index.
  // cand is one bit wider than an index so ptr+i cannot overflow.
  always_comb begin
    winnerFound = 1'b0;
    winner      = '0;
    cand        = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= NbReqW) begin
        cand = cand - NbReqW;
      end
      if (!winnerFound && i_valid[cand[ID_W-1:0]]) begin
        winnerFound = 1'b1;
        winner      = cand[ID_W-1:0];
      end
    end
  end

  // Payload mux written as a compare loop to keep index widths exact.
  always_comb begin
    winnerData = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (winner == ID_W'(k)) begin
        winnerData = i_data[k*DATA_BUS_W +: DATA_BUS_W];
      end
    end
  end

  // srst masks ready so that no upstream beat is consumed while the
  // register is being cleared.
  assign grant = slotFree && winnerFound && !srst;

  always_comb begin
    i_ready = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      i_ready[k] = grant && (winner == ID_W'(k));
    end
  end

  // Next state: srst beats capture; an empty capture only clears valid and
  // leaves data, id and the pointer untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (srst) begin
      valid_d = 1'b0;
      data_d  = '0;
      id_d    = '0;
      ptr_d   = '0;
    end else if (slotFree) begin
      if (winnerFound) begin
        valid_d = 1'b1;
        data_d  = winnerData;
        id_d    = winner;
        ptr_d   = (winner == LastIdx) ? '0 : winner + ID_W'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_id    = id_q;

endmodule

// File: tb/tb_axi_crossbar_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_crossbar_rr_arbiter
//
// Purpose:
//   Self-checking bench for axi_crossbar_rr_arbiter. A 4-requester instance
//   is driven from a table of {inputs, expected ready/valid} rows; granted
//   beats are pushed to a scoreboard queue when driven and popped when the
//   registered output appears. A 3-requester instance checks the explicit
//   pointer wrap.
// ---------------------------------------------------------------------------
module tb_axi_crossbar_rr_arbiter;

  typedef struct packed {
    logic [3:0] valid;
    logic       oReady;
    logic       srst;
    logic [3:0] expReady;
    logic       expValid;
  } vec_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } beat_t;

  logic        aclk;
  logic        aresetn;
  logic        srst;

  logic [3:0]  i_valid;
  logic [63:0] i_data;
  logic [3:0]  i_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic [1:0]  o_id;
  logic        o_ready;

  logic [2:0]  i_valid3;
  logic [47:0] i_data3;
  logic [2:0]  i_ready3;
  logic        o_valid3;
  logic [15:0] o_data3;
  logic [1:0]  o_id3;
  logic        o_ready3;

  int    total = 0;
  int    bad   = 0;
  vec_t  vecs[$];
  beat_t sbQ[$];
  beat_t held;

  axi_crossbar_rr_arbiter #(.NB_REQ(4), .DATA_BUS_W(16)) dut4 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_id    (o_id),
    .o_ready (o_ready)
  );

  axi_crossbar_rr_arbiter #(.NB_REQ(3), .DATA_BUS_W(16)) dut3 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .i_valid (i_valid3),
    .i_data  (i_data3),
    .i_ready (i_ready3),
    .o_valid (o_valid3),
    .o_data  (o_data3),
    .o_id    (o_id3),
    .o_ready (o_ready3)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_valid = v.valid;
    o_ready = v.oReady;
    srst    = v.srst;
  endtask

  task automatic addVec(input logic [3:0] valid, input logic oReady,
                        input logic rst, input logic [3:0] expReady,
                        input logic expValid);
    vecs.push_back({valid, oReady, rst, expReady, expValid});
  endtask

  task automatic runRow(input int n, input vec_t v);
    beat_t b;
    int    idx;
    @(negedge aclk);
    applyStimulus(v);
    #1;
    checkOutput($sformatf("row%0d i_ready", n), 32'(i_ready), 32'(v.expReady));
    if (v.expReady != 4'b0000) begin
      idx = 0;
      for (int k = 0; k < 4; k++) begin
        if (v.expReady[k]) idx = k;
      end
      b.id   = 2'(idx);
      b.data = 16'hA000 + 16'(idx);
      sbQ.push_back(b);
    end
    @(posedge aclk);
    #1;
    checkOutput($sformatf("row%0d o_valid", n), 32'(o_valid), 32'(v.expValid));
    if (v.srst) held = '0;
    if (v.expReady != 4'b0000) held = sbQ.pop_front();
    checkOutput($sformatf("row%0d o_id", n), 32'(o_id), 32'(held.id));
    checkOutput($sformatf("row%0d o_data", n), 32'(o_data), 32'(held.data));
  endtask

  initial begin
    int exp3 [7] = '{0, 1, 2, 0, 1, 2, 0};

    aresetn  = 1'b0;
    srst     = 1'b0;
    i_valid  = '0;
    o_ready  = 1'b1;
    i_valid3 = '0;
    o_ready3 = 1'b1;
    held     = '0;
    for (int k = 0; k < 4; k++) i_data[k*16 +: 16] = 16'hA000 + 16'(k);
    for (int k = 0; k < 3; k++) i_data3[k*16 +: 16] = 16'hB000 + 16'(k);

    // Idle after reset release.
    repeat (5) addVec(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
    // All valid, downstream always ready: 0,1,2,3,0,1.
    addVec(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
    addVec(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);
    addVec(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1);
    addVec(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1);
    addVec(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
    addVec(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);
    // srst wins over a possible capture; then a 3-cycle stall after the
    // first grant, with requester inputs changing underneath it.
    addVec(4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0);
    addVec(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
    addVec(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1);
    addVec(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1);
    addVec(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1);
    addVec(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);
    addVec(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
    // Pointer back to 0, lone requester 2, then 0011 searched from 3.
    addVec(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0);
    addVec(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1);
    addVec(4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1);
    // Empty cycle must not move the pointer (still 1, so 0011 gives 1).
    addVec(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
    addVec(4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1);
    // srst in the middle of a stall discards the held beat.
    addVec(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1);
    addVec(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0);
    addVec(4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1);
    addVec(4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1);
    addVec(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);

    repeat (2) @(posedge aclk);
    #1;
    checkOutput("reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("reset o_id", 32'(o_id), 32'd0);
    checkOutput("reset o_data", 32'(o_data), 32'd0);
    checkOutput("reset i_ready", 32'(i_ready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      runRow(n, vecs[n]);
    end

    // Three requesters, all valid: the pointer must wrap 2 -> 0.
    for (int n = 0; n < 7; n++) begin
      @(negedge aclk);
      i_valid3 = 3'b111;
      #1;
      checkOutput($sformatf("nb3 grant%0d i_ready", n), 32'(i_ready3),
                  32'(3'b001 << exp3[n]));
      @(posedge aclk);
      #1;
      checkOutput($sformatf("nb3 grant%0d o_valid", n), 32'(o_valid3), 32'd1);
      checkOutput($sformatf("nb3 grant%0d o_id", n), 32'(o_id3), 32'(exp3[n]));
      checkOutput($sformatf("nb3 grant%0d o_data", n), 32'(o_data3),
                  32'(16'hB000 + 16'(exp3[n])));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_crossbar_rr_arbiter.md
Name: axi_crossbar_rr_arbiter

Overview:
- Round-robin N:1 arbiter for one AXI crossbar channel (AW, AR, or B/R return path).
- Merges NB_REQ valid/ready request streams into one registered valid/data/id stream.
- The output feeds the crossbar pipeline stage directly downstream, so the output obeys strict valid/ready rules.
- Decision is registered: one stage of buffering with full throughput (one grant per cycle when downstream is ready).

Parameters:
- NB_REQ, 4, number of requesters (2..16).
- DATA_BUS_W, 16, payload width per requester.
- ID_W, $clog2(NB_REQ) (minimum 1), width of the granted-index output.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- srst  input  1  synchronous active-high reset; same effect as aresetn, applied at the clock edge.
- i_valid  input  NB_REQ  per-requester valid.
- i_data  input  NB_REQ*DATA_BUS_W  packed payloads; requester k occupies bits [k*DATA_BUS_W +: DATA_BUS_W].
- i_ready  output  NB_REQ  per-requester ready; one-hot or zero.
- o_valid  output  1  registered output valid.
- o_data  output  DATA_BUS_W  registered payload of the granted requester.
- o_id  output  ID_W  registered index of the granted requester.
- o_ready  input  1  downstream ready.

Behaviour:
- Reset (aresetn low, or srst high at the clock edge): o_valid=0, o_data=0, o_id=0, priority pointer ptr=0. i_ready is then 0 while o_valid=0 is being forced only during srst; see the rule below.
- slot_free = !o_valid || o_ready (combinational).
- Arbitration, combinational:
  - Search requesters in order ptr, ptr+1, …, NB_REQ-1, 0, …, ptr-1 (modulo NB_REQ).
  - The first k with i_valid[k]=1 is the winner.
  - i_ready[k] = slot_free && winner==k && !srst. All other i_ready bits are 0.
  - i_ready never depends on i_valid of the same requester except through winner selection. No combinational path exists from o_ready to o_valid.
- Capture, at a clock edge where slot_free and a winner exist:
  - o_valid<=1, o_data<=i_data[winner], o_id<=winner.
  - ptr <= (winner+1) mod NB_REQ.
- Empty capture, at a clock edge where slot_free and no requester is valid:
  - o_valid<=0.
  - o_data and o_id hold; ptr holds.
- Stall (o_valid && !o_ready):
  - o_valid, o_data, o_id and ptr hold.
  - All i_ready bits are 0.
  - Requester inputs may change freely; the held output is unaffected.
- Latency: one cycle from the i_valid&i_ready handshake to o_valid. Back-to-back handshakes are allowed every cycle while o_ready=1.
- Fairness: a continuously requesting requester is granted within NB_REQ captures. The pointer advances only on a real grant, never on an empty cycle.
- NB_REQ not a power of two: the ptr increment wraps at NB_REQ explicitly. Indices ≥ NB_REQ are never produced.
- Simultaneous events:
  - Downstream handshake and new capture in the same edge is a normal replace; no bubble.
  - srst has priority over capture.
  - A requester dropping i_valid without a handshake (protocol violation upstream) is simply not granted; no error state.
- Reset mid-transfer: a held but unconsumed output beat is discarded. ptr returns to 0.

Test Plan:
- Reset release with all i_valid=0, o_ready=1 → o_valid=0, i_ready=0000, o_id=0 for 5 cycles.
- NB_REQ=4, all i_valid=1111, i_data[k]=16'hA000+k, o_ready=1 → o_id sequence 0,1,2,3,0,1. i_ready one-hot 0001,0010,0100,1000. o_valid=1 every cycle from the 2nd cycle on.
- Same stimulus with o_ready=0 for 3 cycles after the first capture → o_data=16'hA000 and o_id=0 held, i_ready=0000, ptr unchanged. On o_ready=1, the next grant is requester 1 with no skipped or duplicated beat.
- i_valid=0100 only (ptr=0) → requester 2 granted, o_id=2, o_data=i_data[2]. Next cycle i_valid=0011 → requester 0 granted (search 3,0,1,2), not requester 1.
- Mid-stall srst pulse (o_valid=1, o_ready=0) → next cycle o_valid=0, o_data=0, ptr=0. With i_valid=1010 afterwards, requester 1 is granted first.
- NB_REQ=3 with all valid for 7 grants → o_id 0,1,2,0,1,2,0. The value 3 never appears.
